breathing_sequencer: RTL and testbench

//  Schedules NUM_CH breathing PWM channels so exactly one runs at a time.

---
 rtl/breathing_sequencer_if.sv | 25 ++
 rtl/breathing_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_breathing_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/breathing_sequencer_if.sv
// Control/status bundle between the demo logic (master) and the breathing sequencer (slave).
interface breathing_sequencer_if #(
    parameter int unsigned NUM_CH = 4
);
    logic              start;
    logic              stop;
    logic              loop_mode;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_en;
    logic [2:0]        active_ch;
    logic              busy;
    logic              seq_done;
    logic              timeout_err;

    modport master (
        output start, stop, loop_mode, ch_mask, ch_done,
        input  ch_en, active_ch, busy, seq_done, timeout_err
    );

    modport slave (
        input  start, stop, loop_mode, ch_mask, ch_done,
        output ch_en, active_ch, busy, seq_done, timeout_err
    );
endinterface

// File: rtl/breathing_sequencer.sv
// Grants one breathing channel at a time, counts its breaths, inserts an all-off
// gap and steps through the channels selected in the latched mask.
module breathing_sequencer #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned BREATHS_PER_CH = 1,
    parameter int unsigned GAP_CYCLES     = 1024,
    parameter int unsigned RUN_TIMEOUT    = 2**28
) (
    input  logic                  clk,
    input  logic                  reset,
    breathing_sequencer_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam int unsigned GAP_LEN = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam int unsigned BRTH_W  = $clog2(BREATHS_PER_CH) + 1;
    localparam int unsigned GAP_W   = $clog2(GAP_LEN) + 1;
    localparam int unsigned RUN_W   = (RUN_TIMEOUT == 0) ? 1 : $clog2(RUN_TIMEOUT) + 1;
    localparam bit          RUN_LIMIT_EN = (RUN_TIMEOUT != 0);

    localparam logic [BRTH_W-1:0] BRTH_LAST = BRTH_W'(BREATHS_PER_CH - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LEN - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'((RUN_TIMEOUT == 0) ? 0 : RUN_TIMEOUT - 1);

    logic [1:0]        state_q,    state_d;
    logic [NUM_CH-1:0] mask_q,     mask_d;
    logic              loop_q,     loop_d;
    logic              first_q,    first_d;
    logic [2:0]        active_q,   active_d;
    logic [NUM_CH-1:0] ch_en_q,    ch_en_d;
    logic              busy_q,     busy_d;
    logic              seq_done_q, seq_done_d;
    logic              timeout_q,  timeout_d;
    logic [BRTH_W-1:0] brth_cnt_q, brth_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q,  gap_cnt_d;
    logic [RUN_W-1:0]  run_cnt_q,  run_cnt_d;

    logic [2:0] low_idx;
    logic [2:0] above_idx;
    logic       above_found;
    logic [2:0] pick_idx;
    logic       done_hit;

    // Lowest set mask bit overall and lowest set bit above the current channel.
    always_comb begin
        low_idx     = 3'd0;
        above_idx   = 3'd0;
        above_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx = 3'(i);
                if (3'(i) > active_q) begin
                    above_idx   = 3'(i);
                    above_found = 1'b1;
                end
            end
        end
    end

    assign pick_idx = (first_q || !above_found) ? low_idx : above_idx;

    // ch_en_q is one-hot on the running channel, so this masks out foreign done pulses.
    assign done_hit = |(bus.ch_done & ch_en_q);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        loop_d     = loop_q;
        first_d    = first_q;
        active_d   = active_q;
        ch_en_d    = ch_en_q;
        seq_done_d = 1'b0;
        timeout_d  = timeout_q;
        brth_cnt_d = brth_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        run_cnt_d  = run_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.ch_mask != '0)) begin
                    mask_d    = bus.ch_mask;
                    loop_d    = bus.loop_mode;
                    timeout_d = 1'b0;
                    first_d   = 1'b1;
                    state_d   = S_SELECT;
                end
            end
            S_SELECT: begin
                active_d   = pick_idx;
                ch_en_d    = NUM_CH'(1) << pick_idx;
                brth_cnt_d = '0;
                run_cnt_d  = '0;
                first_d    = 1'b0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (done_hit && (brth_cnt_q == BRTH_LAST)) begin
                    ch_en_d   = '0;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    if (done_hit) begin
                        brth_cnt_d = brth_cnt_q + BRTH_W'(1);
                    end
                    if (RUN_LIMIT_EN && (run_cnt_q == RUN_LAST)) begin
                        timeout_d = 1'b1;
                        ch_en_d   = '0;
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else if (RUN_LIMIT_EN) begin
                        run_cnt_d = run_cnt_q + RUN_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    // No set bit above the current channel marks the end of a pass.
                    if (!above_found && !loop_q) begin
                        seq_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_SELECT;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                ch_en_d = '0;
            end
        endcase

        if (bus.stop) begin
            state_d    = S_IDLE;
            ch_en_d    = '0;
            seq_done_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            loop_q     <= 1'b0;
            first_q    <= 1'b0;
            active_q   <= 3'd0;
            ch_en_q    <= '0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
            timeout_q  <= 1'b0;
            brth_cnt_q <= '0;
            gap_cnt_q  <= '0;
            run_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            loop_q     <= loop_d;
            first_q    <= first_d;
            active_q   <= active_d;
            ch_en_q    <= ch_en_d;
            busy_q     <= busy_d;
            seq_done_q <= seq_done_d;
            timeout_q  <= timeout_d;
            brth_cnt_q <= brth_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    assign bus.ch_en       = ch_en_q;
    assign bus.active_ch   = active_q;
    assign bus.busy        = busy_q;
    assign bus.seq_done    = seq_done_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_breathing_sequencer.sv
// Scoreboard bench: expected grant order is queued when a sequence is started
// and popped by a negedge monitor whenever a new grant appears.
module tb_breathing_sequencer;
    localparam int unsigned NCH = 4;
    localparam int unsigned BPC = 2;
    localparam int unsigned GAP = 3;
    localparam int unsigned RTO = 50;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    breathing_sequencer_if #(.NUM_CH(NCH)) bus ();

    breathing_sequencer #(
        .NUM_CH(NCH), .BREATHS_PER_CH(BPC), .GAP_CYCLES(GAP), .RUN_TIMEOUT(RTO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned seq_done_seen = 0;
    int unsigned sd_before;
    logic [3:0]  exp_q[$];
    bit          mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Grant monitor: pops the scoreboard and measures the all-off run between grants.
    logic [3:0]  prev_en = '0;
    int unsigned zero_run = 0;
    bit          seen_grant = 1'b0;
    always @(negedge clk) begin
        logic [3:0] e;
        if (mon_en) begin
            if (bus.seq_done === 1'b1) seq_done_seen++;
            if (bus.busy !== 1'b1) begin
                seen_grant = 1'b0;
                zero_run   = 0;
            end else if (bus.ch_en == '0) begin
                if (seen_grant) zero_run++;
            end else if (prev_en == '0) begin
                if (seen_grant) check_eq("gap_len", zero_run, GAP + 1);
                if (exp_q.size() == 0) begin
                    check_eq("grant_unexpected", 32'(bus.ch_en), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("grant", 32'(bus.ch_en), 32'(e));
                end
                seen_grant = 1'b1;
                zero_run   = 0;
            end
            prev_en = bus.ch_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] m, input logic lp);
        bus.ch_mask   = m;
        bus.loop_mode = lp;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic pulse(input int ch);
        bus.ch_done[ch] = 1'b1;
        tick();
        bus.ch_done = '0;
        tick();
    endtask

    task automatic wait_grant(output int idx);
        int n = 0;
        idx = 0;
        while (bus.ch_en == '0 && n < 60) begin
            tick();
            n++;
        end
        if (bus.ch_en == '0) check_eq("grant_wait", 32'(bus.ch_en != '0), 32'h1);
        for (int i = 0; i < NCH; i++) if (bus.ch_en[i]) idx = i;
    endtask

    task automatic serve(input int n_grants);
        int idx;
        for (int g = 0; g < n_grants; g++) begin
            wait_grant(idx);
            check_eq("active_ch", 32'(bus.active_ch), 32'(idx));
            for (int b = 0; b < BPC; b++) pulse(idx);
        end
    endtask

    task automatic wait_seq_done();
        int n = 0;
        while (bus.seq_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (bus.seq_done === 1'b1) begin
            check_eq("busy_with_done", 32'(bus.busy), 32'h0);
            tick();
            check_eq("seq_done_pulse", 32'(bus.seq_done), 32'h0);
        end else begin
            check_eq("seq_done_wait", 32'(bus.seq_done), 32'h1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ch_en"},  32'(bus.ch_en), 32'h0);
        check_eq({tag, "_active"}, 32'(bus.active_ch), 32'h0);
        check_eq({tag, "_busy"},   32'(bus.busy), 32'h0);
        check_eq({tag, "_done"},   32'(bus.seq_done), 32'h0);
        check_eq({tag, "_tmo"},    32'(bus.timeout_err), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        reset = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_mode = 1'b0;
        bus.ch_mask = '0; bus.ch_done = '0;
        tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // 1: full single pass, with start-to-grant latency
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        do_start(4'b1111, 1'b0);
        check_eq("lat_busy", 32'(bus.busy), 32'h1);
        check_eq("lat_en0", 32'(bus.ch_en), 32'h0);
        tick();
        check_eq("lat_en1", 32'(bus.ch_en), 32'h1);
        serve(4);
        wait_seq_done();
        check_eq("t1_sb_empty", exp_q.size(), 0);
        check_eq("t1_done_cnt", seq_done_seen, 1);

        // 2: looping over a sparse mask, then stop
        sd_before = seq_done_seen;
        exp_q.push_back(4'b0010); exp_q.push_back(4'b1000); exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0010);
        do_start(4'b1010, 1'b1);
        serve(4);
        wait_grant(idx);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_eq("t2_stop_en", 32'(bus.ch_en), 32'h0);
        check_eq("t2_stop_busy", 32'(bus.busy), 32'h0);
        tick(); tick();
        check_eq("t2_no_done", seq_done_seen, sd_before);
        check_eq("t2_sb_empty", exp_q.size(), 0);

        // 3: done pulses from other channels are ignored
        sd_before = seq_done_seen;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0100);
        do_start(4'b0101, 1'b0);
        wait_grant(idx);
        for (int k = 0; k < 5; k++) pulse(2);
        check_eq("t3_foreign", 32'(bus.ch_en), 32'h1);
        pulse(0);
        check_eq("t3_one_breath", 32'(bus.ch_en), 32'h1);
        bus.ch_done[0] = 1'b1;
        tick();
        bus.ch_done = '0;
        check_eq("t3_drop_same_edge", 32'(bus.ch_en), 32'h0);
        tick();
        serve(1);
        wait_seq_done();
        check_eq("t3_done_cnt", seq_done_seen, sd_before + 1);

        // 4: RUN timeout, sequence continues, next start clears the flag
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        do_start(4'b0011, 1'b0);
        wait_grant(idx);
        n = 1;
        while (bus.ch_en != '0 && n < 100) begin
            tick();
            if (bus.ch_en != '0) n++;
        end
        check_eq("t4_run_cycles", n, RTO);
        check_eq("t4_tmo_set", 32'(bus.timeout_err), 32'h1);
        serve(1);
        wait_seq_done();
        check_eq("t4_tmo_sticky", 32'(bus.timeout_err), 32'h1);
        exp_q.push_back(4'b0001);
        do_start(4'b0001, 1'b0);
        check_eq("t4_tmo_clear", 32'(bus.timeout_err), 32'h0);
        serve(1);
        wait_seq_done();
        check_eq("t4_sb_empty", exp_q.size(), 0);

        // 5: empty mask, start vs stop, start while busy
        do_start(4'b0000, 1'b0);
        check_eq("t5_mask0_busy", 32'(bus.busy), 32'h0);
        tick();
        check_eq("t5_mask0_busy2", 32'(bus.busy), 32'h0);
        bus.stop = 1'b1;
        do_start(4'b1111, 1'b0);
        bus.stop = 1'b0;
        check_eq("t5_stop_wins", 32'(bus.busy), 32'h0);
        tick();
        check_eq("t5_stop_wins2", 32'(bus.busy), 32'h0);
        sd_before = seq_done_seen;
        exp_q.push_back(4'b0001);
        do_start(4'b0001, 1'b0);
        wait_grant(idx);
        do_start(4'b1111, 1'b1);
        check_eq("t5_busy_start", 32'(bus.ch_en), 32'h1);
        pulse(0); pulse(0);
        wait_seq_done();
        check_eq("t5_active", 32'(bus.active_ch), 32'h0);
        check_eq("t5_done_cnt", seq_done_seen, sd_before + 1);

        // 6: reset mid-RUN and mid-GAP, then fresh start latency
        exp_q.push_back(4'b0010);
        do_start(4'b1110, 1'b1);
        wait_grant(idx);
        tick(); tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_run");
        reset = 1'b0;
        tick();
        exp_q.push_back(4'b0100);
        do_start(4'b0100, 1'b1);
        wait_grant(idx);
        pulse(2); pulse(2);
        check_eq("t6_in_gap", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_gap");
        reset = 1'b0;
        tick();
        exp_q.push_back(4'b0001);
        do_start(4'b1111, 1'b1);
        check_eq("t6_lat_en0", 32'(bus.ch_en), 32'h0);
        tick();
        check_eq("t6_lat_en1", 32'(bus.ch_en), 32'h1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_eq("t6_stop_en", 32'(bus.ch_en), 32'h0);
        tick();
        check_eq("final_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
